// File: rtl/fd_pkg.sv
// Shared opcode map, ctrl_code layout and forwarding select codes for the IF/ID stage.
package fd_pkg;
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_LOADI = 4'h2;
  localparam logic [3:0] OP_STORE = 4'h3;
  localparam logic [3:0] OP_JMP   = 4'h4;
  localparam logic [3:0] OP_BRZ   = 4'h5;
  localparam logic [3:0] OP_BRNZ  = 4'h6;
  localparam logic [3:0] OP_INOUT = 4'h7;
  localparam logic [3:0] OP_ADD   = 4'h8;
  localparam logic [3:0] OP_SUB   = 4'h9;
  localparam logic [3:0] OP_AND   = 4'hA;
  localparam logic [3:0] OP_OR    = 4'hB;

  // ctrl_code = {DMEM_WE, OPCODE[3:0], RF_WE, RF_ADDR[2:0], OUTPUT}
  localparam int CC_WIDTH   = 10;
  localparam int CC_OUTPUT  = 0;
  localparam int CC_RF_ADDR = 1;
  localparam int CC_RF_WE   = 4;
  localparam int CC_OPCODE  = 5;
  localparam int CC_DMEM_WE = 9;

  localparam logic [2:0] FWD_RF      = 3'd0;
  localparam logic [2:0] FWD_EXEC    = 3'd1;
  localparam logic [2:0] FWD_MEM_ACC = 3'd2;
  localparam logic [2:0] FWD_WB      = 3'd3;
endpackage

// File: rtl/fd_regfile.sv
// 8-entry register file: two asynchronous read ports, one synchronous write port, no bypass.
module fd_regfile #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [2:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [2:0]        raddr_a,
  input  logic [2:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);
  logic [DATA_W-1:0] regs [8];

  always_ff @(posedge clk) begin
    if (we) regs[waddr] <= wdata;
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];
endmodule

// File: rtl/fetch_queue.sv
// Prefetch FIFO of 16-bit instructions; flush empties it and wins over a same-cycle push.
module fetch_queue #(
  parameter int QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  logic [15:0]               wdata,
  output logic [15:0]               rdata,
  output logic [$clog2(QDEPTH):0]   count
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;

  logic [15:0]   mem [QDEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
endmodule

// File: rtl/fetch_decode_stage.sv
// IF/ID stage: prefetch queue fed by a 1-cycle Imem, head decode, in-stage JMP/BRZ/BRNZ redirect.
// Operand forwarding is compiled in only when FD_FORWARD_EN is defined.
module fetch_decode_stage
  import fd_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int QDEPTH = 4
) (
  input  logic                Clk,
  input  logic                Rst,
  output logic                Imem_en,
  output logic [PC_W-1:0]     Imem_addr,
  input  logic [15:0]         Imem_data,
  input  logic                Wb_we,
  input  logic [2:0]          Wb_addr,
  input  logic [DATA_W-1:0]   Wb_data,
  output logic                Out_valid,
  input  logic                Out_ready,
  output logic [CC_WIDTH-1:0] ctrl_code,
  output logic [DATA_W-1:0]   Op_a,
  output logic [DATA_W-1:0]   Op_b,
  output logic [15:0]         IR,
  input  logic [2:0]          Forw_a_ctrl,
  input  logic [2:0]          Forw_b_ctrl,
  input  logic [DATA_W-1:0]   Forward_exec,
  input  logic [DATA_W-1:0]   Forward_mem_acc,
  input  logic [DATA_W-1:0]   Forward_wb
);
  localparam int CW = $clog2(QDEPTH) + 1;

  logic [PC_W-1:0]   pc_p0;
  logic              run_p0;
  logic              vld_p1;
  logic              drop_p1;
  logic [CW-1:0]     count;
  logic [CW-1:0]     occ;
  logic [15:0]       head;
  logic [15:0]       instr;
  logic [3:0]        opcode;
  logic              is_nop, is_load, is_loadi, is_store;
  logic              is_jmp, is_brz, is_brnz, is_inout;
  logic              rf_we, eq0, taken, transfer, flush, push;
  logic [DATA_W-1:0] rf_a, rf_b, sel_a, sel_b;

  function automatic logic [DATA_W-1:0] fwd_sel(input logic [2:0] sel,
                                                input logic [DATA_W-1:0] base,
                                                input logic [DATA_W-1:0] f_exec,
                                                input logic [DATA_W-1:0] f_mem,
                                                input logic [DATA_W-1:0] f_wb);
    case (sel)
      FWD_EXEC:    return f_exec;
      FWD_MEM_ACC: return f_mem;
      FWD_WB:      return f_wb;
      default:     return base;
    endcase
  endfunction

  // Fetch: request while queue plus in-flight response leaves a free slot
  assign occ       = count + CW'(vld_p1);
  assign Imem_en   = run_p0 && (occ < CW'(QDEPTH));
  assign Imem_addr = pc_p0;
  assign push      = vld_p1 && !drop_p1;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pc_p0   <= '0;
      run_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      drop_p1 <= 1'b0;
    end else begin
      run_p0 <= 1'b1;
      vld_p1 <= Imem_en;
      // The request issued alongside a redirect returns next cycle from the wrong path.
      if (flush)       drop_p1 <= Imem_en;
      else if (vld_p1) drop_p1 <= 1'b0;
      if (flush)        pc_p0 <= Op_a[PC_W-1:0];
      else if (Imem_en) pc_p0 <= pc_p0 + 1'b1;
    end
  end

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk   (Clk),
    .rst_n (Rst),
    .push  (push),
    .pop   (transfer),
    .flush (flush),
    .wdata (Imem_data),
    .rdata (head),
    .count (count)
  );

  // Decode: queue head, forced to NOP when nothing is valid
  assign Out_valid = (count != '0);
  assign transfer  = Out_valid && Out_ready;
  assign instr     = Out_valid ? head : 16'h0000;
  assign IR        = instr;
  assign opcode    = instr[15:12];

  assign is_nop   = (opcode == OP_NOP);
  assign is_load  = (opcode == OP_LOAD);
  assign is_loadi = (opcode == OP_LOADI);
  assign is_store = (opcode == OP_STORE);
  assign is_jmp   = (opcode == OP_JMP);
  assign is_brz   = (opcode == OP_BRZ);
  assign is_brnz  = (opcode == OP_BRNZ);
  assign is_inout = (opcode == OP_INOUT);

  assign rf_we = !(is_jmp || is_brz || is_brnz || is_store || is_nop || (is_inout && instr[0]));

  always_comb begin
    ctrl_code                               = '0;
    ctrl_code[CC_DMEM_WE]                   = is_store;
    ctrl_code[CC_OPCODE +: 4]               = opcode;
    ctrl_code[CC_RF_WE]                     = rf_we;
    ctrl_code[CC_RF_ADDR +: 3]              = instr[11:9];
    ctrl_code[CC_OUTPUT]                    = is_inout && instr[0];
  end

  fd_regfile #(.DATA_W(DATA_W)) u_rf (
    .clk     (Clk),
    .we      (Wb_we),
    .waddr   (Wb_addr),
    .wdata   (Wb_data),
    .raddr_a (instr[8:6]),
    .raddr_b (instr[5:3]),
    .rdata_a (rf_a),
    .rdata_b (rf_b)
  );

  assign sel_a = is_loadi ? DATA_W'(instr[7:0]) : rf_a;
  assign sel_b = (is_load && instr[0])  ? DATA_W'(instr[8:1]) :
                 (is_store && instr[0]) ? DATA_W'({instr[11:9], instr[5:1]}) : rf_b;

`ifdef FD_FORWARD_EN
  assign Op_a = fwd_sel(Forw_a_ctrl, sel_a, Forward_exec, Forward_mem_acc, Forward_wb);
  assign Op_b = fwd_sel(Forw_b_ctrl, sel_b, Forward_exec, Forward_mem_acc, Forward_wb);
`else
  logic unused_fwd;
  assign unused_fwd = ^{Forw_a_ctrl, Forw_b_ctrl, Forward_exec, Forward_mem_acc, Forward_wb,
                        fwd_sel(3'd0, sel_a, sel_a, sel_a, sel_a)};
  assign Op_a = sel_a;
  assign Op_b = sel_b;
`endif

  // Branch resolution acts only on an accepted transfer
  assign eq0   = (Op_b == '0);
  assign taken = is_jmp || (is_brz && eq0) || (is_brnz && !eq0);
  assign flush = transfer && taken;
endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage: reset, streaming, backpressure, JMP/BRZ redirect, DATA_W=16 LOADI.
module tb_fetch_decode_stage;
  import fd_pkg::*;

  logic        Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Rst;
  logic        Imem_en;
  logic [7:0]  Imem_addr;
  logic [15:0] Imem_data;
  logic        Wb_we;
  logic [2:0]  Wb_addr;
  logic [7:0]  Wb_data;
  logic        Out_valid;
  logic        Out_ready;
  logic [9:0]  ctrl_code;
  logic [7:0]  Op_a, Op_b;
  logic [15:0] IR;
  logic [2:0]  Forw_a_ctrl, Forw_b_ctrl;
  logic [7:0]  Forward_exec, Forward_mem_acc, Forward_wb;

  logic        imem_en16;
  logic [7:0]  imem_addr16;
  logic [15:0] imem_data16;
  logic        wb_we16 = 1'b0;
  logic [2:0]  wb_addr16 = 3'd0;
  logic [15:0] wb_data16 = 16'h0;
  logic        out_valid16;
  logic        out_ready16 = 1'b1;
  logic [9:0]  ctrl16;
  logic [15:0] op_a16, op_b16, ir16;
  logic [2:0]  fwd_ctrl16 = 3'd0;
  logic [15:0] fwd_val16 = 16'h0;

  fetch_decode_stage u_dut (
    .Clk(Clk), .Rst(Rst), .Imem_en(Imem_en), .Imem_addr(Imem_addr), .Imem_data(Imem_data),
    .Wb_we(Wb_we), .Wb_addr(Wb_addr), .Wb_data(Wb_data), .Out_valid(Out_valid),
    .Out_ready(Out_ready), .ctrl_code(ctrl_code), .Op_a(Op_a), .Op_b(Op_b), .IR(IR),
    .Forw_a_ctrl(Forw_a_ctrl), .Forw_b_ctrl(Forw_b_ctrl), .Forward_exec(Forward_exec),
    .Forward_mem_acc(Forward_mem_acc), .Forward_wb(Forward_wb)
  );

  fetch_decode_stage #(.DATA_W(16)) u_dut16 (
    .Clk(Clk), .Rst(Rst), .Imem_en(imem_en16), .Imem_addr(imem_addr16), .Imem_data(imem_data16),
    .Wb_we(wb_we16), .Wb_addr(wb_addr16), .Wb_data(wb_data16), .Out_valid(out_valid16),
    .Out_ready(out_ready16), .ctrl_code(ctrl16), .Op_a(op_a16), .Op_b(op_b16), .IR(ir16),
    .Forw_a_ctrl(fwd_ctrl16), .Forw_b_ctrl(fwd_ctrl16), .Forward_exec(fwd_val16),
    .Forward_mem_acc(fwd_val16), .Forward_wb(fwd_val16)
  );

  // Instruction memories with 1-cycle read latency
  logic [15:0] rom [256];
  always @(posedge Clk) if (Imem_en) Imem_data <= rom[Imem_addr];
  always @(posedge Clk) if (imem_en16) imem_data16 <= 16'h24A5;

  // Transfer log, sampled mid-cycle
  int          cyc = 0;
  logic        logging = 1'b0;
  logic [15:0] log_ir [$];
  logic [9:0]  log_cc [$];
  logic [7:0]  log_opb [$];
  int          log_cyc [$];

  always @(negedge Clk) begin
    cyc++;
    if (logging && Out_valid && Out_ready) begin
      log_ir.push_back(IR);
      log_cc.push_back(ctrl_code);
      log_opb.push_back(Op_b);
      log_cyc.push_back(cyc);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [7:0] d);
    Wb_we = 1'b1; Wb_addr = a; Wb_data = d;
    tick();
    Wb_we = 1'b0;
  endtask

  task automatic clear_log;
    log_ir.delete(); log_cc.delete(); log_opb.delete(); log_cyc.delete();
  endtask

  task automatic start_run;
    Rst = 1'b0;
    tick();
    clear_log();
    Rst = 1'b1;
    logging = 1'b1;
  endtask

  logic [15:0] hold_ir;
  logic [7:0]  hold_opa;
  logic        seen4;
  logic        exp_taken;
  logic [7:0]  exp_opb_load, exp_opb_store;
  int          k;

  initial begin
    Rst = 1'b1; Out_ready = 1'b1; Wb_we = 1'b0; Wb_addr = 3'd0; Wb_data = 8'h0;
    Forw_a_ctrl = 3'd0; Forw_b_ctrl = 3'd0;
    Forward_exec = 8'h0; Forward_mem_acc = 8'h0; Forward_wb = 8'h0;
    for (int i = 0; i < 256; i++) rom[i] = 16'h8000 | 16'(i);

    #2 Rst = 1'b0;
    #1;
    check("rst_out_valid", Out_valid, 1'b0);
    check("rst_imem_en", Imem_en, 1'b0);
    check("rst_out_valid16", out_valid16, 1'b0);
    tick();
    wb_write(3'd1, 8'h20);

    // Reset mid-stream, then straight-line fill and throughput
    Rst = 1'b1;
    logging = 1'b1;
    repeat (6) tick();
    Rst = 1'b0;
    #1;
    check("midrst_out_valid", Out_valid, 1'b0);
    check("midrst_imem_en", Imem_en, 1'b0);
    tick();
    clear_log();
    Rst = 1'b1;
    k = 0;
    while (!Imem_en && k < 5) begin tick(); k++; end
    check("first_imem_en", Imem_en, 1'b1);
    check("first_imem_addr", Imem_addr, 8'h00);
    tick();
    check("fill_valid_c1", Out_valid, 1'b0);
    tick();
    check("fill_valid_c2", Out_valid, 1'b1);
    check("fill_ir_c2", IR, rom[0]);
    repeat (8) tick();
    check("stream_len", (log_ir.size() >= 6), 1'b1);
    if (log_ir.size() >= 6) check("stream_rate", log_cyc[5] - log_cyc[0], 5);

    // Backpressure: queue fills, fetch stops, outputs hold
    Out_ready = 1'b0;
    #1;
    hold_ir = IR;
    hold_opa = Op_a;
    repeat (10) tick();
    check("bp_count", u_dut.count, 3'd4);
    check("bp_imem_en", Imem_en, 1'b0);
    check("bp_valid", Out_valid, 1'b1);
    check("bp_ir_hold", IR, hold_ir);
    check("bp_opa_hold", Op_a, hold_opa);
    Out_ready = 1'b1;
    repeat (12) tick();
    check("seq_len", (log_ir.size() >= 16), 1'b1);
    for (int i = 0; i < log_ir.size(); i++) check($sformatf("seq[%0d]", i), log_ir[i], rom[i]);

    // JMP r1 (r1=0x20) at address 3
    rom[3] = 16'h4040;
    start_run();
    repeat (14) tick();
    check("jmp_len", (log_ir.size() >= 6), 1'b1);
    if (log_ir.size() >= 6) begin
      check("jmp_ir", log_ir[3], 16'h4040);
      check("jmp_ctrl", log_cc[3], 10'h080);
      check("jmp_target_ir", log_ir[4], rom[8'h20]);
      check("jmp_next_ir", log_ir[5], rom[8'h21]);
      check("jmp_redirect_lat", log_cyc[4] - log_cyc[3], 3);
    end
    seen4 = 1'b0;
    foreach (log_ir[i]) if (log_ir[i] == rom[4]) seen4 = 1'b1;
    check("jmp_no_rom4", seen4, 1'b0);
    rom[3] = 16'h8003;

    // LOAD/STORE immediates and BRZ on forwarded vs RF operand
    rom[0] = 16'h18D7;
    rom[1] = 16'h3A3F;
    rom[2] = 16'h5058;
    rom[3] = 16'h7C01;
    Forw_b_ctrl = FWD_EXEC;
    for (int run = 0; run < 2; run++) begin
      wb_write(3'd3, (run == 0) ? 8'h05 : 8'h00);
      Forward_exec = (run == 0) ? 8'h00 : 8'h05;
`ifdef FD_FORWARD_EN
      exp_taken     = (run == 0);
      exp_opb_load  = Forward_exec;
      exp_opb_store = Forward_exec;
`else
      exp_taken     = (run == 1);
      exp_opb_load  = 8'h6B;
      exp_opb_store = 8'hBF;
`endif
      start_run();
      repeat (12) tick();
      check($sformatf("br%0d_len", run), (log_ir.size() >= 4), 1'b1);
      if (log_ir.size() >= 4) begin
        check($sformatf("br%0d_load_ir", run), log_ir[0], 16'h18D7);
        check($sformatf("br%0d_load_ctrl", run), log_cc[0], 10'h038);
        check($sformatf("br%0d_load_opb", run), log_opb[0], exp_opb_load);
        check($sformatf("br%0d_store_ctrl", run), log_cc[1], 10'h26A);
        check($sformatf("br%0d_store_opb", run), log_opb[1], exp_opb_store);
        check($sformatf("br%0d_brz_ctrl", run), log_cc[2], 10'h0A0);
        check($sformatf("br%0d_after_ir", run), log_ir[3], exp_taken ? rom[8'h20] : 16'h7C01);
        check($sformatf("br%0d_after_ctrl", run), log_cc[3], exp_taken ? 10'h110 : 10'h0ED);
      end
    end
    Forw_b_ctrl = FWD_RF;

    // DATA_W=16 instance streaming LOADI r2,0xA5
    check("w16_valid", out_valid16, 1'b1);
    check("w16_ir", ir16, 16'h24A5);
    check("w16_opa", op_a16, 16'h00A5);
    check("w16_ctrl", ctrl16, 10'h054);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
